onehot_request_encoder: RTL
===========================

// Module: onehot_request_encoder
// PURPOSE
//   Sticky N-way request collector and one-hot -> binary encoder; the encoding end of SELECT_1_TO_N.
//   Captures single-cycle request pulses, then offers one pending request per cycle as a binary
//   index plus a matching one-hot grant, using a valid/ready handshake.
//   Sits between requesting units and a shared resource (e.g. memory port, output FIFO).
// PARAMETERS
//   SEL_WIDTH    4   width of binary index Sel; REQ_WIDTH <= 2**SEL_WIDTH (elaboration error otherwise)
//   REQ_WIDTH    16  number of request lines
//   ROUND_ROBIN  0   0 = fixed priority (lowest index wins); 1 = round-robin from last offered index+1
// PORTS
//   Clock         in   1            rising-edge clock
//   Reset         in   1            asynchronous, active-low reset
//   Req           in   REQ_WIDTH    request pulses; bit i high at an edge arms request i
//   Flush         in   1            synchronous clear of all pending and offered requests
//   Ready         in   1            consumer accepts the offer at this edge
//   Valid         out  1            an offer is presented on Sel/Grant
//   Sel           out  SEL_WIDTH    binary index of the offered request
//   Grant         out  REQ_WIDTH    one-hot of Sel when Valid, else 0
//   Pending       out  REQ_WIDTH    armed requests not yet offered (registered)
//   PendingCount  out  SEL_WIDTH+1  popcount of Pending (registered, same edge as Pending)
// BEHAVIOUR
// - Reset low: Valid=0, Sel=0, Grant=0, Pending=0, PendingCount=0, RR pointer=0. Takes effect
//   immediately, including mid-offer; the offered request is lost.
// - States: IDLE (Valid=0), OFFER (Valid=1). Every output is a flop; no combinational path from
//   inputs to outputs.
// - Load event: an edge in IDLE, or an edge in OFFER with Ready=1 (transfer).
//   At a load event, Cand = Pending | Req.
//     Cand != 0: pick index k (priority rule), Sel<=k, Grant<=1<<k, Valid<=1,
//                Pending <= Cand & ~(1<<k).
//     Cand == 0: Valid<=0, Grant<=0, Sel holds its value, Pending<=0.
// - Edge in OFFER with Ready=0: Sel/Grant/Valid held stable (no preemption by a higher-priority
//   request); Pending <= Pending | Req.
// - Latency: Req at edge t while IDLE -> Valid=1 after edge t. Back-to-back transfers: one per
//   cycle while Cand != 0.
// - Duplicate Req on an already-pending bit merges (one offer). Req on the currently offered bit
//   re-arms it in Pending, including at the transfer edge; that bit is offered again later.
// - Priority: ROUND_ROBIN=0: lowest set index. ROUND_ROBIN=1: first set index searching upward
//   from ptr with wrap at REQ_WIDTH-1 -> 0. ptr <= k+1 (mod REQ_WIDTH) at each load that sets Valid.
// - Flush=1 at an edge (overrides Req/Ready): Pending<=0, Valid<=0, Grant<=0, ptr held; Req at
//   that edge is dropped.
// - PendingCount always equals popcount(Pending); max value REQ_WIDTH.
// - Ready while Valid=0 is ignored. Req bits at index >= REQ_WIDTH do not exist.
// TESTING
// 1. Fixed prio: Req=16'h0024 for one cycle, Ready=1 -> Valid 2 cycles, Sel=2 then 5,
//    Grant=0004/0020, then Valid=0, PendingCount=0.
// 2. Backpressure: offering Sel=5, Ready=0 for 3 cycles, Req=16'h0001 -> Sel stays 5, Pending=0001,
//    PendingCount=1; Ready=1 -> Sel=0 next.
// 3. ROUND_ROBIN=1, Req=16'hFFFF held, Ready=1 -> Sel 0,1,...,15,0,1 with Valid continuously 1.
// 4. Re-arm: offering Sel=3; Req=16'h0008 at the transfer edge -> Sel=3 offered again after the
//    other pending bits, per priority.
// 5. Flush with Req=16'h00F0 at the same edge, Pending=16'h000F -> next cycle Valid=0, Pending=0,
//    Grant=0.
// 6. Reset low mid-offer (Valid=1, Pending=16'h0300) -> outputs 0 immediately, without waiting
//    for a clock edge; after release, Req=16'h0100 -> Sel=8.

Source files
------------

// File: rtl/onehot_request_encoder.sv
// onehot_request_encoder: sticky N-way request collector and one-hot -> binary encoder.
// Armed request pulses are held in pending. One pending request is offered per cycle
// as a binary index (sel) and a one-hot grant, under a valid/ready handshake.
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req           request pulses; bit i high at an edge arms request i
//   flush         synchronous clear of all pending and offered requests
//   ready         consumer accepts the current offer at this edge
//   valid         an offer is presented on sel/grant
//   sel           binary index of the offered request
//   grant         one-hot of sel while valid, else 0
//   pending       armed requests not yet offered
//   pending_count popcount of pending
module onehot_request_encoder #(
    parameter int SEL_WIDTH   = 4,
    parameter int REQ_WIDTH   = 16,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_WIDTH-1:0] req,
    input  logic                 flush,
    input  logic                 ready,
    output logic                 valid,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [REQ_WIDTH-1:0] grant,
    output logic [REQ_WIDTH-1:0] pending,
    output logic [SEL_WIDTH:0]   pending_count
);
    if (REQ_WIDTH > 2 ** SEL_WIDTH) begin : g_bad_width
        $error("REQ_WIDTH exceeds 2**SEL_WIDTH");
    end

    typedef enum logic {IDLE, OFFER} state_t;

    state_t               state, state_n;
    logic [SEL_WIDTH-1:0] sel_n, ptr, ptr_n, k;
    logic [REQ_WIDTH-1:0] grant_n, pending_n, cand, sh;
    logic                 found;
    int                   idx;

    assign valid = (state == OFFER);

    always_comb begin
        cand  = pending | req;
        found = 1'b0;
        k     = '0;
        idx   = 0;
        sh    = '0;
        // Scan from ptr (round-robin) or from 0 (fixed), wrapping at REQ_WIDTH.
        for (int i = 0; i < REQ_WIDTH; i++) begin
            idx = ROUND_ROBIN ? int'(ptr) + i : i;
            if (idx >= REQ_WIDTH) idx = idx - REQ_WIDTH;
            sh = cand >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                k     = SEL_WIDTH'(idx);
            end
        end
        state_n   = state;
        sel_n     = sel;
        grant_n   = grant;
        pending_n = pending | req;
        ptr_n     = ptr;
        if (flush) begin
            state_n   = IDLE;
            grant_n   = '0;
            pending_n = '0;
        end else if (state == IDLE || ready) begin
            state_n   = found ? OFFER : IDLE;
            sel_n     = found ? k : sel;
            grant_n   = found ? REQ_WIDTH'(1) << k : '0;
            pending_n = found ? cand & ~(REQ_WIDTH'(1) << k) : '0;
            ptr_n     = found ? (k == SEL_WIDTH'(REQ_WIDTH - 1) ? '0 : k + SEL_WIDTH'(1)) : ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sel           <= '0;
            grant         <= '0;
            pending       <= '0;
            pending_count <= '0;
            ptr           <= '0;
        end else begin
            state         <= state_n;
            sel           <= sel_n;
            grant         <= grant_n;
            pending       <= pending_n;
            pending_count <= (SEL_WIDTH + 1)'($countones(pending_n));
            ptr           <= ptr_n;
        end
    end
endmodule
